// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32 x 32-bit architectural register file, one write port and two
// combinational read ports. Entry 0 is hardwired to zero.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to
// a read port whose index matches the active write index.
module regfile_2r1w #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  // Flat view of all entries, entry[0] tied to zero, feeding both read selectors.
  logic [DATA_W-1:0] entry [NumRegs];

  for (genvar i = 0; i < NumRegs; i++) begin : g_entry
    if (i == 0) begin : g_zero
      assign entry[i] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] reg_q;
      logic              we;

      // Decoder term is ANDed with the enable first so an X index with the
      // enable low cannot disturb the register.
      assign we = ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(i));

      // Enabled register with asynchronous clear.
      always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
          reg_q <= '0;
        end else if (we) begin
          reg_q <= data_writeReg;
        end
      end

      assign entry[i] = reg_q;
    end
  end

  logic fwd_a;
  logic fwd_b;

`ifdef REGFILE_BYPASS_EN
  assign fwd_a = ctrl_writeEnable && (ctrl_writeReg != '0) && (ctrl_readRegA == ctrl_writeReg);
  assign fwd_b = ctrl_writeEnable && (ctrl_writeReg != '0) && (ctrl_readRegB == ctrl_writeReg);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // Read port A: select, optional forward, forced to zero during reset.
  always_comb begin
    data_readRegA = entry[ctrl_readRegA];
    if (fwd_a) begin
      data_readRegA = data_writeReg;
    end
    if (!ctrl_reset_n) begin
      data_readRegA = '0;
    end
  end

  // Read port B: select, optional forward, forced to zero during reset.
  always_comb begin
    data_readRegB = entry[ctrl_readRegB];
    if (fwd_b) begin
      data_readRegB = data_writeReg;
    end
    if (!ctrl_reset_n) begin
      data_readRegB = '0;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed self-checking bench for regfile_2r1w.
module tb_regfile_2r1w;

  logic        clock;
  logic        ctrl_reset_n;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  int checks;
  int failures;

  regfile_2r1w #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single write: drive at negedge, commit on the following posedge.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clock);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = addr;
    data_writeReg    = data;
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic test_reset();
    // Held in reset from time 0.
    ctrl_readRegA = 5'd3;
    ctrl_readRegB = 5'd31;
    #2;
    checks++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      failures++;
      $display("FAIL reset_initial got A=%h B=%h expected 0", data_readRegA, data_readRegB);
    end
    #10 ctrl_reset_n = 1'b1;
    do_write(5'd5, 32'h0000_0055);
    ctrl_readRegA = 5'd5;
    #1;
    checks++;
    if (data_readRegA !== 32'h0000_0055) begin
      failures++;
      $display("FAIL reset_preload got %h expected 00000055", data_readRegA);
    end
    // Assert reset mid-cycle; the clear must be visible before the next posedge.
    @(negedge clock);
    ctrl_reset_n = 1'b0;
    #1;
    checks++;
    if (data_readRegA !== 32'h0) begin
      failures++;
      $display("FAIL reset_async_clear got %h expected 0", data_readRegA);
    end
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      #1;
      checks++;
      if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
        failures++;
        $display("FAIL reset_sweep idx=%0d got A=%h B=%h expected 0", i, data_readRegA,
                 data_readRegB);
      end
    end
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    // Clear must persist after release, not only be masked on the outputs.
    ctrl_readRegA = 5'd5;
    #1;
    checks++;
    if (data_readRegA !== 32'h0) begin
      failures++;
      $display("FAIL reset_release got %h expected 0", data_readRegA);
    end
  endtask

  task automatic test_write_read_all();
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'hA5A5_0000 | 32'(i));
    end
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      exp_a = (i == 0) ? 32'h0 : (32'hA5A5_0000 | 32'(i));
      exp_b = (i == 31) ? 32'h0 : (32'hA5A5_0000 | 32'(31 - i));
      #1;
      checks++;
      if (data_readRegA !== exp_a || data_readRegB !== exp_b) begin
        failures++;
        $display("FAIL write_read_all idx=%0d got A=%h B=%h expected A=%h B=%h", i,
                 data_readRegA, data_readRegB, exp_a, exp_b);
      end
    end
    // Both ports on the same index.
    ctrl_readRegA = 5'd17;
    ctrl_readRegB = 5'd17;
    #1;
    checks++;
    if (data_readRegA !== 32'hA5A5_0011 || data_readRegB !== 32'hA5A5_0011) begin
      failures++;
      $display("FAIL same_index got A=%h B=%h expected a5a50011", data_readRegA, data_readRegB);
    end
  endtask

  task automatic test_r0();
    @(negedge clock);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'hFFFF_FFFF;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;
    #1;
    checks++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      failures++;
      $display("FAIL r0_same_cycle got A=%h B=%h expected 0", data_readRegA, data_readRegB);
    end
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
    checks++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      failures++;
      $display("FAIL r0_after_edge got A=%h B=%h expected 0", data_readRegA, data_readRegB);
    end
  endtask

  task automatic test_enable_gating();
    do_write(5'd7, 32'h1234_5678);
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd7;
    data_writeReg    = 32'hDEAD_BEEF;
    repeat (5) @(posedge clock);
    #1;
    ctrl_readRegA = 5'd7;
    ctrl_readRegB = 5'd6;
    #1;
    checks++;
    if (data_readRegA !== 32'h1234_5678) begin
      failures++;
      $display("FAIL enable_gating got %h expected 12345678", data_readRegA);
    end
    checks++;
    if (data_readRegB !== 32'hA5A5_0006) begin
      failures++;
      $display("FAIL enable_gating_neighbour got %h expected a5a50006", data_readRegB);
    end
    // X index with enable low must not corrupt anything.
    @(negedge clock);
    ctrl_writeReg = 5'bxxxxx;
    @(posedge clock);
    #1;
    ctrl_writeReg = 5'd0;
    checks++;
    if (data_readRegA !== 32'h1234_5678 || data_readRegB !== 32'hA5A5_0006) begin
      failures++;
      $display("FAIL x_index got A=%h B=%h expected 12345678 a5a50006", data_readRegA,
               data_readRegB);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_before;
    do_write(5'd9, 32'h0000_0001);
    @(negedge clock);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd9;
    data_writeReg    = 32'h0000_0002;
    ctrl_readRegA    = 5'd9;
    ctrl_readRegB    = 5'd10;
`ifdef REGFILE_BYPASS_EN
    exp_before = 32'h0000_0002;
`else
    exp_before = 32'h0000_0001;
`endif
    #1;
    checks++;
    if (data_readRegA !== exp_before) begin
      failures++;
      $display("FAIL same_cycle_before got %h expected %h", data_readRegA, exp_before);
    end
    checks++;
    if (data_readRegB !== 32'hA5A5_000A) begin
      failures++;
      $display("FAIL same_cycle_other_port got %h expected a5a5000a", data_readRegB);
    end
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
    #1;
    checks++;
    if (data_readRegA !== 32'h0000_0002) begin
      failures++;
      $display("FAIL same_cycle_after got %h expected 00000002", data_readRegA);
    end
  endtask

  task automatic test_reset_mid_write();
    do_write(5'd4, 32'h0000_0044);
    @(negedge clock);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'hCAFE_BABE;
    ctrl_reset_n     = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    ctrl_reset_n     = 1'b1;
    ctrl_readRegA    = 5'd3;
    ctrl_readRegB    = 5'd4;
    #1;
    checks++;
    if (data_readRegA !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_write_r3 got %h expected 0", data_readRegA);
    end
    checks++;
    if (data_readRegB !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_write_r4 got %h expected 0", data_readRegB);
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    ctrl_reset_n     = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'h0;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;

    test_reset();
    test_write_read_all();
    test_r0();
    test_enable_gating();
    test_same_cycle();
    test_reset_mid_write();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- 32-entry x 32-bit architectural register file for the processor datapath.
- Upstream of the 32:1 read-select stage. Holds register state, accepts one write per clock and presents two combinational read ports (A, B) to decode/execute.
- Register 0 is hardwired to zero.
- Internally: a 5-to-32 write-enable decoder, 31 enabled 32-bit registers, and two 32:1 read selectors.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, register index width; entry count is 2**ADDR_W (32).

Ports:
- clock  input  1  rising-edge clock for all state.
- ctrl_reset_n  input  1  asynchronous active-low reset; clears all registers.
- ctrl_writeEnable  input  1  write strobe, sampled on rising clock.
- ctrl_writeReg  input  ADDR_W  destination register index.
- data_writeReg  input  DATA_W  write data.
- ctrl_readRegA  input  ADDR_W  read port A index.
- ctrl_readRegB  input  ADDR_W  read port B index.
- data_readRegA  output  DATA_W  read port A data, combinational.
- data_readRegB  output  DATA_W  read port B data, combinational.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - ctrl_reset_n low forces all entries r1..r31 to 0 immediately, with no wait for a clock edge.
  - While reset is asserted, both read outputs are 0 for any index.
  - Deassertion is synchronised externally; the block needs no synchroniser.
- Write:
  - On a rising clock with ctrl_reset_n high and ctrl_writeEnable=1, entry[ctrl_writeReg] <= data_writeReg.
  - Exactly one entry is written per cycle; all other entries hold.
  - ctrl_writeEnable=0: no entry changes, regardless of index or data.
- Register 0:
  - A write to index 0 is discarded.
  - Reads of index 0 always return 0, including same-cycle write-to-0 with bypass enabled.
- Read:
  - data_readRegX = entry[ctrl_readRegX], purely combinational from the index and register state.
  - Zero-cycle latency from an index change.
  - The value written at edge N is visible on reads after edge N (one-cycle write-to-read latency without bypass).
- Simultaneous events:
  - A and B may read the same index; both return the same value.
  - Read and write to the same index in the same cycle, without the optional feature: the read returns the old value until the edge, the new value after it.
  - Reset asserted during a write cycle: reset wins and the entry stays 0.
- Width: no arithmetic. Data is stored and returned bit-exact; indices are unsigned and cover the full 0..31 range with no wrap logic.
- Unknowns: X on ctrl_writeReg while ctrl_writeEnable=0 must not corrupt any entry, so the decoder is gated by the enable.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if ctrl_writeEnable=1, ctrl_writeReg!=0 and ctrl_readRegX==ctrl_writeReg, then data_readRegX = data_writeReg combinationally in the same cycle.
  - Applies to A and B independently.
  - Gives the pipeline same-cycle writeback visibility.
  - Reset still forces outputs to 0.
- Undefined: no forwarding path; behaviour exactly as in the Read rules above.

Test Plan:
- Reset then read all: pulse ctrl_reset_n low mid-cycle with no clock edge, then sweep A and B over 0..31 -> all reads 0, and the clear is seen before the next clock edge.
- Write/read every register: write value 0xA5A50000|i to each i=1..31, then read A=i, B=31-i -> A returns 0xA5A50000|i; B returns 0xA5A50000|(31-i), or 0 when 31-i=0.
- r0 protection: write 0xFFFFFFFF to index 0 with enable=1, then read A=0 and B=0 -> both 0 in the same cycle and after the edge.
- Enable gating: set ctrl_writeEnable=0 with ctrl_writeReg=7 and data=0xDEADBEEF for 5 clocks, after r7 was loaded with 0x12345678 -> r7 still reads 0x12345678.
- Same-cycle read/write on r9, old value 0x1, writing 0x2:
  - REGFILE_BYPASS_EN undefined: A=9 reads 0x1 before the edge and 0x2 after it.
  - REGFILE_BYPASS_EN defined: A=9 reads 0x2 in the same cycle.
- Reset mid-write: assert ctrl_reset_n low in the cycle that writes 0xCAFEBABE to r3 -> after release, r3 reads 0 and r4 (preloaded 0x44) also reads 0.
